// File: rtl/shift_operand_fetch_if.sv
// shift_operand_fetch_if: instruction, register-file and shifter-operand
// signals of shift_operand_fetch bundled into one interface.
// Optional feature macro: SHIFT_RRX_EN (adds op_rrx).
//
// Handshakes: instr and op transfer on a rising clock edge where the
// producer's valid and the consumer's ready are both high; a producer holds
// valid and its payload stable until that edge. The register file has no
// handshake: rf_rdata answers an rf_req exactly one cycle later.
interface shift_operand_fetch_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        rf_req;
    logic [3:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rm;
    logic [1:0]  op_type;
    logic [7:0]  op_amount;
    logic        op_by_reg;
`ifdef SHIFT_RRX_EN
    logic        op_rrx;
`endif
    logic [2:0]  dbg_state;

    // The fetch block itself.
    modport slave (
        input  instr_valid, instr, rf_rdata, op_ready,
        output instr_ready, rf_req, rf_addr, op_valid,
               op_rm, op_type, op_amount, op_by_reg,
`ifdef SHIFT_RRX_EN
               op_rrx,
`endif
               dbg_state
    );

    // Decode stage, register file and shifter around it.
    modport master (
        output instr_valid, instr, rf_rdata, op_ready,
        input  instr_ready, rf_req, rf_addr, op_valid,
               op_rm, op_type, op_amount, op_by_reg,
`ifdef SHIFT_RRX_EN
               op_rrx,
`endif
               dbg_state
    );
endinterface

// File: rtl/shift_operand_fetch.sv
// shift_operand_fetch: decodes the ARM operand-2 field, reads Rm/Rs through
// one register-file port and presents barrel-shifter operands.
// Optional feature macro: SHIFT_RRX_EN (ROR #0 encodes RRX, op_rrx output).
module shift_operand_fetch (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_operand_fetch_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_RM  = 3'd1,
        CAP_RM = 3'd2,
        CAP_RS = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rm_idx;
    logic [3:0]  rs_idx;
    logic [31:0] op_rm_q;
    logic [1:0]  op_type_q;
    logic [7:0]  op_amount_q;
    logic        op_by_reg_q;
    logic        instr_ready_c;
    logic        op_valid_c;
    logic        rf_req_c;
    logic [3:0]  rf_addr_c;
    logic        accept;

    // Decode helpers for the instruction currently offered.
    logic        is_imm;
    logic        is_by_reg;
    logic [4:0]  shamt;
    logic [1:0]  sh_type;
    logic [7:0]  imm_amount;

    assign accept     = bus.instr_valid && instr_ready_c;
    assign is_imm     = bus.instr[25];
    assign is_by_reg  = !bus.instr[25] && bus.instr[4];
    assign shamt      = bus.instr[11:7];
    assign sh_type    = bus.instr[6:5];

    // Immediate shift amount: #0 means 32 for LSR/ASR, stays 0 for LSL/ROR.
    always_comb begin
        imm_amount = {3'b000, shamt};
        if (shamt == 5'd0 && (sh_type == 2'b01 || sh_type == 2'b10))
            imm_amount = 8'd32;
    end

`ifdef SHIFT_RRX_EN
    logic op_rrx_q;
    // RRX flag: only shift-by-immediate ROR #0 requests a rotate-through-carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_rrx_q <= 1'b0;
        else if (accept)
            op_rrx_q <= !is_imm && !bus.instr[4] && sh_type == 2'b11 && shamt == 5'd0;
    end
    assign bus.op_rrx = op_rrx_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, handshake and register-file read strobes.
    always_comb begin
        state_d       = state_q;
        instr_ready_c = 1'b0;
        op_valid_c    = 1'b0;
        rf_req_c      = 1'b0;
        rf_addr_c     = 4'd0;
        case (state_q)
            IDLE: begin
                instr_ready_c = 1'b1;
                if (bus.instr_valid)
                    state_d = is_imm ? OUT : RD_RM;
            end
            RD_RM: begin
                rf_req_c  = 1'b1;
                rf_addr_c = rm_idx;
                state_d   = CAP_RM;
            end
            CAP_RM: begin
                if (op_by_reg_q) begin
                    rf_req_c  = 1'b1;
                    rf_addr_c = rs_idx;
                    state_d   = CAP_RS;
                end else begin
                    state_d = OUT;
                end
            end
            CAP_RS: state_d = OUT;
            OUT: begin
                op_valid_c = 1'b1;
                if (bus.op_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers: decode fields at accept, register data as it returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rm_idx      <= 4'd0;
            rs_idx      <= 4'd0;
            op_rm_q     <= 32'd0;
            op_type_q   <= 2'b00;
            op_amount_q <= 8'd0;
            op_by_reg_q <= 1'b0;
        end else if (accept) begin
            rm_idx      <= bus.instr[3:0];
            rs_idx      <= bus.instr[11:8];
            op_by_reg_q <= is_by_reg;
            if (is_imm) begin
                op_rm_q     <= {24'd0, bus.instr[7:0]};
                op_type_q   <= 2'b11;
                op_amount_q <= {3'b000, bus.instr[11:8], 1'b0};
            end else begin
                op_type_q   <= sh_type;
                op_amount_q <= is_by_reg ? 8'd0 : imm_amount;
            end
        end else if (state_q == CAP_RM) begin
            op_rm_q <= bus.rf_rdata;
        end else if (state_q == CAP_RS) begin
            op_amount_q <= bus.rf_rdata[7:0];
        end
    end

    assign bus.instr_ready = instr_ready_c;
    assign bus.op_valid    = op_valid_c;
    assign bus.rf_req      = rf_req_c;
    assign bus.rf_addr     = rf_addr_c;
    assign bus.op_rm       = op_rm_q;
    assign bus.op_type     = op_type_q;
    assign bus.op_amount   = op_amount_q;
    assign bus.op_by_reg   = op_by_reg_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_shift_operand_fetch.sv
// tb_shift_operand_fetch: directed and randomized instructions against an
// operand-2 decode reference model with a small register-file model.
module tb_shift_operand_fetch;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] regs [16];
    logic        pend_valid;
    logic [31:0] pend_data;
    logic [43:0] exp_q [$];

    shift_operand_fetch_if bus ();

    shift_operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Register-file model: data appears one cycle after the strobe, garbage otherwise.
    initial begin
        pend_valid   = 1'b0;
        pend_data    = 32'd0;
        bus.rf_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.rf_rdata = pend_valid ? pend_data : $urandom;
            pend_valid   = bus.rf_req;
            pend_data    = regs[bus.rf_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] observed();
        logic rrx;
`ifdef SHIFT_RRX_EN
        rrx = bus.op_rrx;
`else
        rrx = 1'b0;
`endif
        return {bus.op_rm, bus.op_type, bus.op_amount, bus.op_by_reg, rrx};
    endfunction

    // Reference: operand-2 semantics written straight from the instruction encoding.
    function automatic logic [43:0] model(input logic [31:0] ins, output int lat);
        logic [31:0] rm;
        logic [1:0]  ty;
        int          amt;
        logic        by_reg;
        logic        rrx;
        by_reg = 1'b0;
        rrx    = 1'b0;
        if (ins[25]) begin
            rm  = {24'd0, ins[7:0]};
            ty  = 2'b11;
            amt = 2 * int'(ins[11:8]);
            lat = 1;
        end else begin
            rm = regs[ins[3:0]];
            ty = ins[6:5];
            if (ins[4]) begin
                amt    = int'(regs[ins[11:8]] % 256);
                by_reg = 1'b1;
                lat    = 4;
            end else begin
                amt = int'(ins[11:7]);
                if (amt == 0 && (ty == 2'b01 || ty == 2'b10)) amt = 32;
`ifdef SHIFT_RRX_EN
                rrx = (amt == 0 && ty == 2'b11);
`endif
                lat = 3;
            end
        end
        return {rm, ty, amt[7:0], by_reg, rrx};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, bus.instr_ready, 1);
        check({tag, "_rf_req"},      bus.rf_req, 0);
        check({tag, "_rf_addr"},     bus.rf_addr, 0);
        check({tag, "_op_valid"},    bus.op_valid, 0);
        check({tag, "_op_fields"},   observed(), 0);
    endtask

    // One instruction from offer to operand handshake; called at a negedge in IDLE.
    task automatic run_op(input logic [31:0] ins, input int stall);
        int          lat;
        int          cyc;
        logic [43:0] exp;
        logic        exp_req;
        logic [3:0]  exp_addr;
        exp = model(ins, lat);
        exp_q.push_back(exp);
        check("offer_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.op_ready    = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        cyc = 1;
        while (!bus.op_valid && cyc < 12) begin
            exp_req  = 1'b0;
            exp_addr = 4'd0;
            if (!ins[25] && cyc == 1) begin
                exp_req  = 1'b1;
                exp_addr = ins[3:0];
            end else if (!ins[25] && ins[4] && cyc == 2) begin
                exp_req  = 1'b1;
                exp_addr = ins[11:8];
            end
            check("rf_req", bus.rf_req, exp_req);
            check("rf_addr", bus.rf_addr, exp_addr);
            check("busy_ready", bus.instr_ready, 0);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", bus.op_valid, 1);
            check("stall_ready", bus.instr_ready, 0);
            check("stall_fields", observed(), exp_q[0]);
            check("stall_rf_req", bus.rf_req, 0);
            @(negedge clk);
        end
        check("op_valid", bus.op_valid, 1);
        check("op_fields", observed(), exp_q.pop_front());
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
        check("post_valid", bus.op_valid, 0);
        check("post_ready", bus.instr_ready, 1);
    endtask

    initial begin
        logic [31:0] ins;
        int          kind;
        n_checks        = 0;
        n_errors        = 0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.op_ready    = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[1] = 32'hCAFE_0001;
        regs[2] = 32'h1234_5678;
        regs[3] = 32'h8000_0000;
        regs[4] = 32'h0000_0121;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(32'h0200_04FF, 0);
        run_op(32'h0000_0282, 0);
        run_op(32'h0000_0021, 0);
        run_op(32'h0000_0060, 0);
        run_op(32'h0000_0453, 0);
        run_op(32'h0000_0453, 3);
        run_op(32'h0000_0282, 0);
        run_op(32'h0000_0333, 1);

        // Reset during CAP_RM of a register shift.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0000_0453;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("discard_valid", bus.op_valid, 0);
            check("discard_ready", bus.instr_ready, 1);
            @(negedge clk);
        end

        // Randomized instructions.
        for (int n = 0; n < 60; n++) begin
            ins  = $urandom;
            kind = $urandom_range(0, 3);
            case (kind)
                0: ins[25] = 1'b1;
                1: begin ins[25] = 1'b0; ins[4] = 1'b0; end
                2: begin ins[25] = 1'b0; ins[4] = 1'b0; ins[11:7] = 5'd0; end
                default: begin ins[25] = 1'b0; ins[4] = 1'b1; end
            endcase
            if (n % 7 == 0) regs[$urandom_range(0, 15)] = $urandom;
            run_op(ins, $urandom_range(0, 3));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
